// File: rtl/alu_result_display.sv
// alu_result_display
// Display stage for the ALU datapath. Captures a 6-bit result (unsigned or
// two's complement), converts its magnitude to two BCD digits with a
// sequential double-dabble, and scans the 4-digit multiplexed
// seven-segment display.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   result_in    in   [5:0] ALU result
//   result_valid in   one-cycle strobe, accepted only when idle
//   signed_mode  in   1 = two's complement, 0 = unsigned
//   busy         out  high while a conversion is in progress
//   an           out  [3:0] digit enables, active-low, an[3] leftmost
//   seg          out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp           out  decimal point, active-low, always off
module alu_result_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] result_in,
    input  logic       result_valid,
    input  logic       signed_mode,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    // Magnitude of the captured result. Six bits are enough: -32 negates to
    // 6'b100000, which read as unsigned is 32.
    function automatic logic [5:0] magnitude(input logic [5:0] r, input logic s);
        logic [5:0] m;
        if (s && r[5]) begin
            m = (~r) + 6'd1;
        end else begin
            m = r;
        end
        return m;
    endfunction

    // One double-dabble iteration: correct nibbles >= 5, then shift in b.
    function automatic logic [7:0] dabble_step(input logic [7:0] bcd, input logic b);
        logic [7:0] t;
        t = bcd;
        if (t[3:0] >= 4'd5) begin
            t[3:0] = t[3:0] + 4'd3;
        end else begin
            t[3:0] = t[3:0];
        end
        if (t[7:4] >= 4'd5) begin
            t[7:4] = t[7:4] + 4'd3;
        end else begin
            t[7:4] = t[7:4];
        end
        return {t[6:0], b};
    endfunction

    // Active-low segment pattern for a decimal digit.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic             busy_r;
    logic [5:0]       mag_r;
    logic             neg_r;
    logic [7:0]       bcd_r;
    logic [2:0]       bit_cnt_r;
    logic [3:0]       disp_ones_r;
    logic [3:0]       disp_tens_r;
    logic             disp_neg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic [1:0]       idx_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; strobes are only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (result_valid) begin
                    state_s = CONVERT;
                end else begin
                    state_s = IDLE;
                end
            end
            CONVERT: begin
                if (bit_cnt_r == 3'd5) begin
                    state_s = LOAD;
                end else begin
                    state_s = CONVERT;
                end
            end
            LOAD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // busy registered alongside the state so it equals (state != IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
        end
    end

    // Capture and double-dabble conversion datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r     <= 6'd0;
            neg_r     <= 1'b0;
            bcd_r     <= 8'd0;
            bit_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (result_valid) begin
                        mag_r     <= magnitude(result_in, signed_mode);
                        neg_r     <= signed_mode & result_in[5];
                        bcd_r     <= 8'd0;
                        bit_cnt_r <= 3'd0;
                    end
                end
                CONVERT: begin
                    bcd_r     <= dabble_step(bcd_r, mag_r[5]);
                    mag_r     <= {mag_r[4:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                default: begin
                    bcd_r <= bcd_r;
                end
            endcase
        end
    end

    // Display registers: updated only in LOAD, so the previous value stays
    // visible for the whole conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_ones_r <= 4'd0;
            disp_tens_r <= 4'd0;
            disp_neg_r  <= 1'b0;
        end else if (state_r == LOAD) begin
            disp_ones_r <= bcd_r[3:0];
            disp_tens_r <= bcd_r[7:4];
            disp_neg_r  <= neg_r;
        end
    end

    // Free-running refresh timer and digit index, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Index the pins will show after this edge. Using the next index keeps
    // every position, including the first after reset, low for exactly
    // REFRESH_DIV cycles.
    always_comb begin
        idx_s = idx_r;
        if (cnt_r == CNT_MAX) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
    end

    // Digit enable and segment selection for the position being shown.
    always_comb begin
        an_s  = 4'b1111;
        seg_s = SEG_BLANK;
        case (idx_s)
            2'd0: begin
                an_s  = 4'b1110;
                seg_s = digit_seg(disp_ones_r);
            end
            2'd1: begin
                an_s = 4'b1101;
                if (disp_tens_r == 4'd0) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = digit_seg(disp_tens_r);
                end
            end
            2'd2: begin
                an_s = 4'b1011;
                if (disp_neg_r) begin
                    seg_s = SEG_MINUS;
                end else begin
                    seg_s = SEG_BLANK;
                end
            end
            default: begin
                an_s  = 4'b0111;
                seg_s = SEG_BLANK;
            end
        endcase
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 4'b1110;
            seg_r <= 7'b1000000;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
        end
    end

    assign busy = busy_r;
    assign an   = an_r;
    assign seg  = seg_r;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] result_in = 6'd0;
    logic       result_valid = 1'b0;
    logic       signed_mode = 1'b0;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    alu_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_in    (result_in),
        .result_valid (result_valid),
        .signed_mode  (signed_mode),
        .busy         (busy),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] DIG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         rc;          // edges since reset
    int         bc;          // busy cycles still to come
    bit         mvalid = 1'b0;
    bit         d_neg, p_neg;
    int         d_mag, p_mag;
    logic       e_busy;
    logic [3:0] e_an;
    logic [6:0] e_seg;

    function automatic logic [6:0] model_seg(input int pos, input bit neg, input int mag);
        if (pos == 0) return DIG[mag % 10];
        if (pos == 1) return (mag / 10 == 0) ? BLANK : DIG[mag / 10];
        if (pos == 2) return neg ? MINUS : BLANK;
        return BLANK;
    endfunction

    always @(posedge clk) begin
        int  v;
        int  pos;
        bit  load;
        load = 1'b0;
        if (rst) begin
            rc = 0; bc = 0; d_neg = 1'b0; d_mag = 0; mvalid = 1'b1;
        end else begin
            rc++;
            if (bc == 0) begin
                if (result_valid) begin
                    v = int'(result_in);
                    if (signed_mode && v >= 32) v = v - 64;
                    p_neg = (v < 0);
                    p_mag = (v < 0) ? -v : v;
                    bc = 7;
                end
            end else begin
                bc--;
                if (bc == 0) load = 1'b1;
            end
        end
        pos    = (rc / DIV) % 4;
        e_busy = (bc != 0);
        e_an   = ~(4'b0001 << pos);
        e_seg  = model_seg(pos, d_neg, d_mag);
        if (load) begin
            d_neg = p_neg;
            d_mag = p_mag;
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (mvalid) begin
            chk("busy", busy, e_busy);
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("dp", dp, 1'b1);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic strobe(input logic [5:0] v, input logic m);
        @(negedge clk);
        result_in    = v;
        signed_mode  = m;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic scan(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] got [4];
        for (int k = 0; k < 4; k++) got[k] = 7'bx;
        @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: got[0] = 7'bx;
            endcase
            @(negedge clk);
        end
        chk({nm, "_d3"}, got[3], e3);
        chk({nm, "_d2"}, got[2], e2);
        chk({nm, "_d1"}, got[1], e1);
        chk({nm, "_d0"}, got[0], e0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] an_tab [4];
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset and scan order
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_dp", dp, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 5 * DIV; i++) begin
            chk("scan_an", an, an_tab[(i / DIV) % 4]);
            @(negedge clk);
        end

        // Unsigned maximum: 63
        strobe(6'b111111, 1'b0);
        wait_busy(n);
        chk("umax_busy_len", n, 7);
        scan("umax", BLANK, BLANK, 7'b0000010, 7'b0110000);

        // Signed minimum: -32
        strobe(6'b100000, 1'b1);
        wait_busy(n);
        chk("smin_busy_len", n, 7);
        scan("smin", BLANK, MINUS, 7'b0110000, 7'b0100100);

        // Signed -1 with tens blanking, then the same bits unsigned
        strobe(6'b111111, 1'b1);
        wait_busy(n);
        scan("sneg1", BLANK, MINUS, BLANK, 7'b1111001);
        strobe(6'b111111, 1'b0);
        wait_busy(n);
        scan("u63", BLANK, BLANK, 7'b0000010, 7'b0110000);

        // Second strobe three cycles into a conversion is ignored
        strobe(6'd5, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (n == 2) begin
                result_in    = 6'd42;
                result_valid = 1'b1;
            end else begin
                result_valid = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        result_valid = 1'b0;
        chk("ovl_busy_len", n, 7);
        scan("ovl", BLANK, BLANK, BLANK, 7'b0010010);

        // Reset in the middle of a conversion
        strobe(6'd47, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_an", an, 4'b1110);
        chk("midrst_seg", seg, 7'b1000000);
        scan("midrst", BLANK, BLANK, BLANK, 7'b1000000);
        strobe(6'd9, 1'b0);
        wait_busy(n);
        chk("nine_busy_len", n, 7);
        scan("nine", BLANK, BLANK, BLANK, 7'b0010000);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
